// File: rtl/unidade_controle_exp3_pkg.sv
// State codes shared by the control unit and anything decoding db_estado.
package unidade_controle_exp3_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        COMPARA     = 4'h3,
        PROXIMO     = 4'h4,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_exp3_detector_borda.sv
// Registered rising-edge detector: one pulse per 0->1 transition of sinal.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;

    always_ff @(posedge clock) begin
        if (reset) sinal_q <= 1'b0;
        else       sinal_q <= sinal;
    end

    assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_exp3.sv
// Moore control unit for the Exp.3 counter/comparator round: sequence entry, error and timeout.
module unidade_controle_exp3
    import unidade_controle_exp3_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 5000,
    parameter int unsigned TIMER_WIDTH    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam logic [TIMER_WIDTH-1:0] LIMITE =
        TIMER_WIDTH'((TIMEOUT_CICLOS == 0) ? 0 : TIMEOUT_CICLOS - 1);

    estado_t                estado, proximo_estado;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   pulso;

    detector_borda u_borda (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (pulso)
    );

    // Timer restarts at zero on every entry into ESPERA and saturates.
    always_ff @(posedge clock) begin
        if (reset || estado != ESPERA) timer <= '0;
        else if (timer != '1)          timer <= timer + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo_estado;
    end

    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL:  proximo_estado = iniciar ? PREPARA : INICIAL;
            PREPARA:  proximo_estado = ESPERA;
            ESPERA: begin
                if (pulso)
                    proximo_estado = COMPARA;
                else if (TIMEOUT_CICLOS != 0 && timer == LIMITE)
                    proximo_estado = FIM_TIMEOUT;
                else
                    proximo_estado = ESPERA;
            end
            COMPARA: begin
                if (!igual)   proximo_estado = FIM_ERRO;
                else if (fim) proximo_estado = FIM_ACERTO;
                else          proximo_estado = PROXIMO;
            end
            PROXIMO:  proximo_estado = ESPERA;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
                proximo_estado = iniciar ? PREPARA : estado;
            default:  proximo_estado = INICIAL;
        endcase
    end

    always_comb begin
        zera    = 1'b0;
        conta   = 1'b0;
        pronto  = 1'b0;
        acertou = 1'b0;
        errou   = 1'b0;
        timeout = 1'b0;
        case (estado)
            PREPARA:     zera = 1'b1;
            PROXIMO:     conta = 1'b1;
            FIM_ACERTO:  begin pronto = 1'b1; acertou = 1'b1; end
            FIM_TIMEOUT: begin pronto = 1'b1; timeout = 1'b1; end
            FIM_ERRO:    begin pronto = 1'b1; errou   = 1'b1; end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_exp3.sv
// Directed bench for unidade_controle_exp3 with a small counter/comparator datapath model.
module tb_unidade_controle_exp3;
    import unidade_controle_exp3_pkg::*;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada;
    logic [3:0] chaves;
    logic       igual, fim;
    logic       zera, conta, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    logic       reset_to, iniciar_to;
    logic       zera_to, conta_to, pronto_to, acertou_to, errou_to, timeout_to;
    logic [3:0] db_estado_to;

    int tests  = 0;
    int failed = 0;
    int conta_pulses = 0;

    logic [3:0] cnt = '0;

    always #5 clock = ~clock;

    unidade_controle_exp3 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fim(fim), .zera(zera), .conta(conta),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    unidade_controle_exp3 #(.TIMEOUT_CICLOS(8), .TIMER_WIDTH(16)) dut_to (
        .clock(clock), .reset(reset_to), .iniciar(iniciar_to), .jogada(1'b0),
        .igual(1'b0), .fim(1'b0), .zera(zera_to), .conta(conta_to),
        .pronto(pronto_to), .acertou(acertou_to), .errou(errou_to), .timeout(timeout_to),
        .db_estado(db_estado_to)
    );

    // Datapath model: 4-bit counter cleared by zera, advanced by conta.
    always @(posedge clock) begin
        if (zera)       cnt <= '0;
        else if (conta) cnt <= cnt + 4'd1;
        if (conta === 1'b1) conta_pulses <= conta_pulses + 1;
    end
    assign igual = (cnt == chaves);
    assign fim   = (cnt == 4'd15);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, state %h", db_estado);
        $fatal(1, "watchdog");
    end

    // Called at a negedge in ESPERA; ends at the negedge where ESPERA or a FIM state is shown.
    task automatic press(input logic [3:0] v, input logic [3:0] esperado);
        chaves = v;
        jogada = 1'b1;
        @(negedge clock);
        tests++;
        if (db_estado !== COMPARA) begin
            failed++;
            $display("FAIL press_compara v=%0d: state %h, want %h", v, db_estado, COMPARA);
        end
        jogada = 1'b0;
        @(negedge clock);
        tests++;
        if (db_estado !== esperado) begin
            failed++;
            $display("FAIL press_result v=%0d: state %h, want %h", v, db_estado, esperado);
        end
        if (esperado == 4'h4) begin
            tests++;
            if (conta !== 1'b1) begin
                failed++;
                $display("FAIL press_conta v=%0d: conta %b, want 1", v, conta);
            end
            @(negedge clock);
            tests++;
            if (db_estado !== ESPERA) begin
                failed++;
                $display("FAIL press_back v=%0d: state %h, want 2", v, db_estado);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b1; jogada = 1'b0; chaves = '0;
        repeat (2) @(negedge clock);
        tests++;
        if (db_estado !== 4'h0) begin
            failed++; $display("FAIL reset_state: state %h, want 0", db_estado);
        end
        tests++;
        if ({zera, conta, pronto, acertou, errou, timeout} !== 6'b0) begin
            failed++;
            $display("FAIL reset_outputs: %b, want 000000", {zera, conta, pronto, acertou, errou, timeout});
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (db_estado !== 4'h1 || zera !== 1'b1) begin
            failed++; $display("FAIL reset_prepara: state %h zera %b, want 1/1", db_estado, zera);
        end
        iniciar = 1'b0;
        @(negedge clock);
        tests++;
        if (db_estado !== 4'h2 || zera !== 1'b0) begin
            failed++; $display("FAIL reset_espera: state %h zera %b, want 2/0", db_estado, zera);
        end
    endtask

    task automatic test_success();
        int base;
        base = conta_pulses;
        for (int v = 0; v < 16; v++) begin
            if (v == 15) press(4'(v), 4'hA);
            else         press(4'(v), 4'h4);
        end
        tests++;
        if ({pronto, acertou, errou, timeout} !== 4'b1100 || db_estado !== 4'hA) begin
            failed++;
            $display("FAIL success_flags: pr/ac/er/to %b state %h, want 1100/A",
                     {pronto, acertou, errou, timeout}, db_estado);
        end
        tests++;
        if (conta_pulses - base !== 15) begin
            failed++; $display("FAIL success_conta_count: %0d, want 15", conta_pulses - base);
        end
    endtask

    task automatic test_error();
        int base;
        iniciar = 1'b1;
        @(negedge clock);
        tests++;
        if (db_estado !== 4'h1 || zera !== 1'b1) begin
            failed++; $display("FAIL error_restart: state %h zera %b, want 1/1", db_estado, zera);
        end
        iniciar = 1'b0;
        @(negedge clock);
        base = conta_pulses;
        press(4'd0, 4'h4);
        press(4'd1, 4'h4);
        press(4'd5, 4'hE);
        tests++;
        if ({pronto, acertou, errou, timeout} !== 4'b1010) begin
            failed++;
            $display("FAIL error_flags: pr/ac/er/to %b, want 1010", {pronto, acertou, errou, timeout});
        end
        repeat (2) @(negedge clock);
        tests++;
        if (db_estado !== 4'hE || conta_pulses - base !== 2) begin
            failed++;
            $display("FAIL error_hold: state %h conta %0d, want E/2", db_estado, conta_pulses - base);
        end
    endtask

    task automatic test_restart();
        iniciar = 1'b1;
        @(negedge clock);
        tests++;
        if (db_estado !== 4'h1 || zera !== 1'b1) begin
            failed++; $display("FAIL restart_prepara: state %h zera %b, want 1/1", db_estado, zera);
        end
        iniciar = 1'b0;
        @(negedge clock);
        tests++;
        if (db_estado !== 4'h2 || zera !== 1'b0) begin
            failed++; $display("FAIL restart_espera: state %h zera %b, want 2/0", db_estado, zera);
        end
    endtask

    task automatic test_held();
        int n_compara, n_proximo, base;
        n_compara = 0; n_proximo = 0;
        base = conta_pulses;
        chaves = 4'd0;
        jogada = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (db_estado === 4'h3) n_compara++;
            if (db_estado === 4'h4) n_proximo++;
        end
        jogada = 1'b0;
        tests++;
        if (n_compara != 1 || n_proximo != 1) begin
            failed++;
            $display("FAIL held_once: compara %0d proximo %0d, want 1/1", n_compara, n_proximo);
        end
        tests++;
        if (db_estado !== 4'h2 || conta_pulses - base !== 1) begin
            failed++;
            $display("FAIL held_final: state %h conta %0d, want 2/1", db_estado, conta_pulses - base);
        end
    endtask

    task automatic test_reset_midround();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (db_estado !== 4'h0 || zera !== 1'b0) begin
            failed++; $display("FAIL midreset_state: state %h zera %b, want 0/0", db_estado, zera);
        end
        reset = 1'b0;
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        @(negedge clock);
        tests++;
        if (db_estado !== 4'h0 || zera !== 1'b0) begin
            failed++; $display("FAIL midreset_idle: state %h zera %b, want 0/0", db_estado, zera);
        end
    endtask

    task automatic test_timeout();
        reset_to = 1'b0;
        iniciar_to = 1'b1;
        @(negedge clock);
        tests++;
        if (db_estado_to !== 4'h1) begin
            failed++; $display("FAIL timeout_prepara: state %h, want 1", db_estado_to);
        end
        iniciar_to = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            tests++;
            if (db_estado_to !== 4'h2) begin
                failed++; $display("FAIL timeout_wait cycle %0d: state %h, want 2", i, db_estado_to);
            end
        end
        @(negedge clock);
        tests++;
        if (db_estado_to !== 4'hD || timeout_to !== 1'b1 || pronto_to !== 1'b1 || errou_to !== 1'b0) begin
            failed++;
            $display("FAIL timeout_end: state %h to %b pr %b er %b, want D/1/1/0",
                     db_estado_to, timeout_to, pronto_to, errou_to);
        end
    endtask

    initial begin
        reset_to = 1'b1; iniciar_to = 1'b0;
        test_reset();
        test_success();
        test_error();
        test_restart();
        test_held();
        test_reset_midround();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
